// File: rtl/combinational_logic_pkg.sv
// Shared constants and types for the configurable 3-input Boolean function unit.
package combinational_logic_pkg;

   localparam int unsigned TT_W  = 8;
   localparam int unsigned IDX_W = 3;

   typedef logic [TT_W-1:0]  tt_t;
   typedef logic [IDX_W-1:0] idx_t;

   // F = sum of minterms 1,2,4,6
   localparam tt_t TT_DEFAULT = 8'b0101_0110;

   function automatic logic tt_lookup(input tt_t table_i, input idx_t idx_i);
      return table_i[idx_i];
   endfunction

endpackage

// File: rtl/combinational_logic.sv
// Reprogrammable 3-input lookup: F = tt[{A,B,C}], with a registered copy F_q.
module combinational_logic
   import combinational_logic_pkg::*;
#(
   parameter tt_t DEFAULT_TT = TT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             tt_we,
   input  logic [TT_W-1:0]  tt_wdata,
   output logic             F,
   output logic             F_q,
   output logic [IDX_W-1:0] minterm,
   output logic [TT_W-1:0]  tt
);

   tt_t  r_tt;
   logic r_f_q;
   idx_t w_minterm;
   logic w_f;

   // Output is held low during reset even though the table is still live.
   always_comb begin
      w_minterm = {A, B, C};
      w_f       = 1'b0;
      if (!rst) begin
         w_f = tt_lookup(r_tt, w_minterm);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tt  <= DEFAULT_TT;
         r_f_q <= 1'b0;
      end else begin
         if (tt_we) begin
            r_tt <= tt_wdata;
         end
         r_f_q <= w_f;
      end
   end

   assign F       = w_f;
   assign F_q     = r_f_q;
   assign minterm = w_minterm;
   assign tt      = r_tt;

endmodule

// File: tb/tb_combinational_logic.sv
// Self-checking bench: per-cycle model comparison plus directed literal checks.
module tb_combinational_logic;

   logic       clk;
   logic       rst;
   logic       A, B, C;
   logic       tt_we;
   logic [7:0] tt_wdata;
   logic       F;
   logic       F_q;
   logic [2:0] minterm;
   logic [7:0] tt;

   int n_tests;
   int n_fail;

   combinational_logic dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .C        (C),
      .tt_we    (tt_we),
      .tt_wdata (tt_wdata),
      .F        (F),
      .F_q      (F_q),
      .minterm  (minterm),
      .tt       (tt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: table contents and last registered value.
   logic [7:0] m_tt;
   logic       m_fq;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_tt    = 8'h56;
         m_fq    = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_fq = (m_tt >> {A, B, C}) & 8'h01;
         if (tt_we) m_tt = tt_wdata;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_minterm", {5'd0, minterm}, {5'd0, A, B, C});
         check("model_tt", tt, m_tt);
         check("model_F", {7'd0, F}, rst ? 8'd0 : ((m_tt >> {A, B, C}) & 8'h01));
         check("model_F_q", {7'd0, F_q}, {7'd0, m_fq});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_abc(input logic [2:0] v);
      {A, B, C} = v;
   endtask

   // Hand-written default function values for minterms 0..7.
   logic exp_def [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tt_we    = 1'b0;
      tt_wdata = 8'h00;
      set_abc(3'b101);
      step();
      step();
      rst = 1'b0;
      #2;
      check("rst_F_101", {7'd0, F}, 8'd0);
      check("rst_minterm", {5'd0, minterm}, 8'h05);
      check("rst_tt", tt, 8'b0101_0110);
      step();
      #2;
      check("rst_F_q", {7'd0, F_q}, 8'd0);

      for (int i = 0; i < 8; i++) begin
         set_abc(i[2:0]);
         #2;
         check("sweep_F", {7'd0, F}, {7'd0, exp_def[i]});
         check("sweep_F_q", {7'd0, F_q}, (i == 0) ? 8'd0 : {7'd0, exp_def[i-1]});
         step();
      end

      set_abc(3'b101);
      tt_we    = 1'b1;
      tt_wdata = 8'hFF;
      #2;
      check("pre_write_F", {7'd0, F}, 8'd0);
      step();
      tt_we = 1'b0;
      #2;
      check("wr_FF_F", {7'd0, F}, 8'd1);
      check("wr_FF_tt", tt, 8'hFF);
      check("wr_FF_F_q_lag", {7'd0, F_q}, 8'd0);
      step();
      #2;
      check("wr_FF_F_q", {7'd0, F_q}, 8'd1);

      tt_we    = 1'b1;
      tt_wdata = 8'h20;
      step();
      tt_we = 1'b0;
      #2;
      check("wr_20_tt", tt, 8'h20);
      check("wr_20_F", {7'd0, F}, 8'd1);
      rst      = 1'b1;
      tt_we    = 1'b1;
      tt_wdata = 8'h00;
      step();
      rst   = 1'b0;
      tt_we = 1'b0;
      #2;
      check("rst_wins_tt", tt, 8'b0101_0110);
      check("rst_wins_F", {7'd0, F}, 8'd0);

      rst = 1'b1;
      set_abc(3'b001);
      #2;
      check("hold_rst_F", {7'd0, F}, 8'd0);
      step();
      #2;
      check("hold_rst_F2", {7'd0, F}, 8'd0);
      check("hold_rst_F_q", {7'd0, F_q}, 8'd0);
      step();
      rst = 1'b0;
      #2;
      check("release_F", {7'd0, F}, 8'd1);
      check("release_F_q_lag", {7'd0, F_q}, 8'd0);
      step();
      #2;
      check("release_F_q", {7'd0, F_q}, 8'd1);

      step();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/combinational_logic.md
Name: combinational_logic

Overview:
- Three-input single-output Boolean function unit; output F is a combinational lookup of {A,B,C}.
- Lookup is driven by an 8-entry truth-table register, so the function can be reprogrammed at run time.
- Also provides a registered copy of F and the decoded minterm index.
- Used as a small glue-logic/decision element wherever a configurable 3-input function is needed.

Parameters:
- DEFAULT_TT, 8'b0101_0110, truth table loaded on reset. Bit i is the value of F for minterm i = {A,B,C}. The default is F = Σm(1,2,4,6); minterm 5 (A=1, B=0, C=1) gives F=0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- A  input  1  function input, MSB of minterm index
- B  input  1  function input, middle bit of minterm index
- C  input  1  function input, LSB of minterm index
- tt_we  input  1  truth-table write enable
- tt_wdata  input  8  new truth table, same bit ordering as DEFAULT_TT
- F  output  1  combinational function output
- F_q  output  1  F registered, one-cycle latency
- minterm  output  3  combinational {A,B,C}
- tt  output  8  current truth-table register contents

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Minterm decode: minterm = {A,B,C}, with A as the MSB; purely combinational.
- Function output: F = tt[minterm], purely combinational, zero latency.
  - F is forced to 0 while rst=1.
- Truth-table register:
  - On a rising clk edge with rst=1: tt <= DEFAULT_TT and F_q <= 0.
  - On a rising clk edge with rst=0 and tt_we=1: tt <= tt_wdata.
  - A new table affects F from the cycle after the write edge. F_q picks it up one edge later still.
  - If tt_we=0, tt holds its value.
- Simultaneous rst=1 and tt_we=1: reset wins and tt becomes DEFAULT_TT.
- Registered output: on each rising edge with rst=0, F_q <= F. F_q therefore lags F by exactly one cycle.
- Reset mid-operation: takes effect at the next edge. Any programmed table is discarded and DEFAULT_TT is restored.
- Default function values (minterm 0..7): 0,1,1,0,1,0,1,0.
  - A=1, B=0, C=1 gives F=0.
  - A=0, B=0, C=1 gives F=1.
- No X-propagation handling is required. Inputs are assumed to be driven.

Decomposition:
- Shared package holds:
  - constant TT_W = 8
  - constant IDX_W = 3
  - DEFAULT_TT value 8'b0101_0110
  - typedef for the truth-table vector
- No sub-module. The register, mux and output flop sit in one module.

Test Plan:
- Reset, then A,B,C = 1,0,1 -> F=0, minterm=3'b101, tt=8'b01010110; one cycle later F_q=0.
- After reset, sweep minterm 0..7 with one value per cycle -> F = 0,1,1,0,1,0,1,0; F_q repeats that sequence one cycle later.
- tt_we=1, tt_wdata=8'hFF for one cycle, hold A,B,C = 1,0,1 -> F=1 from the next cycle, F_q=1 one cycle after that.
- Program tt=8'h20, then assert rst and tt_we=1 with tt_wdata=8'h00 on the same edge -> tt=8'b01010110 afterwards; F(1,0,1)=0.
- Hold rst=1 with A,B,C = 0,0,1 -> F=0 and F_q=0; release rst -> F=1 immediately, F_q=1 after one edge.
